// File: rtl/at93c46d_pkg.sv
// ----------------------------------------------------------------------------
// at93c46d_pkg
//   Shared definitions for the AT93C46D command sequencer.
//   - Two-bit opcodes that the engine places in front of the 6-bit address.
//   - Fixed EWEN / EWDS command bytes. Both use opcode 2'b00 and are told
//     apart by the upper address bits.
//   - FSM state and command-step encodings.
//   - step_cmd(): builds the engine command byte for a given step.
// ----------------------------------------------------------------------------
package at93c46d_pkg;

    localparam logic [1:0] OP_READ      = 2'b10;
    localparam logic [1:0] OP_WRITE     = 2'b01;
    localparam logic [1:0] OP_ERASE     = 2'b11;
    localparam logic [1:0] OP_EWEN_EWDS = 2'b00;

    localparam logic [7:0] CMD_EWEN = {OP_EWEN_EWDS, 6'b110000};
    localparam logic [7:0] CMD_EWDS = {OP_EWEN_EWDS, 6'b000000};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_CS_HI,
        ST_WAIT_CS_LO,
        ST_TWR_WAIT,
        ST_RESP
    } state_t;

    // Position within a request's command list:
    //   READ        : MAIN
    //   WRITE/ERASE : EWEN, MAIN, (tWR), EWDS[, VERIFY]
    typedef enum logic [1:0] {
        STEP_EWEN,
        STEP_MAIN,
        STEP_EWDS,
        STEP_VERIFY
    } step_t;

    function automatic logic [7:0] step_cmd(input step_t step,
                                            input logic [1:0] op,
                                            input logic [5:0] addr);
        logic [7:0] cmd;
        case (step)
            STEP_EWEN:   cmd = CMD_EWEN;
            STEP_EWDS:   cmd = CMD_EWDS;
            STEP_VERIFY: cmd = {OP_READ, addr};
            default:     cmd = {op, addr};
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/at93c46d_wait_timer.sv
// ----------------------------------------------------------------------------
// at93c46d_wait_timer
//   Saturating up-counter. The sequencer shares one instance for the
//   chip-select timeouts and for the tWR hold-off.
// Ports
//   clk    in   system clock
//   rst    in   synchronous reset, active high (clears the count)
//   load   in   clear the count to zero (restarts a measurement)
//   en     in   count this cycle
//   limit  in   CNT_W  terminal value; the count never goes past it
//   done   out  count has reached limit
// ----------------------------------------------------------------------------
module at93c46d_wait_timer #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (en && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count >= limit);

endmodule

// File: rtl/at93c46d_sequencer.sv
// ----------------------------------------------------------------------------
// at93c46d_sequencer
//   Command sequencer between the host register bank and the AT93C46D serial
//   engine. It takes one READ / WRITE / ERASE request at a time. WRITE and
//   ERASE are wrapped in EWEN ... EWDS, and the self-timed program cycle (tWR)
//   is waited out before EWDS. Each request ends with a one-cycle response.
//
// Configuration
//   AT93C46D_WRITE_VERIFY_EN : when defined, a successful WRITE/ERASE is
//     followed by a read-back of the same address. rsp_rdata returns the
//     word read back. rsp_err is set if that word differs from the written
//     data, or from 16'hFFFF for ERASE.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous reset, active high
//   req_valid     in   host request valid
//   req_ready     out  idle and engine not busy
//   req_op        in   2  2'b10 READ, 2'b01 WRITE, 2'b11 ERASE, 2'b00 reserved
//   req_addr      in   6  word address
//   req_wdata     in   16 write data
//   rsp_valid     out  one-cycle completion pulse
//   rsp_rdata     out  16 read data (held until the next response)
//   rsp_err       out  timeout / reserved op / verify mismatch (held)
//   spi_start     out  engine start pulse (one cycle per command)
//   spi_cmd       out  8  {opcode, addr} to engine
//   spi_data_in   out  16 write data to engine
//   spi_cs        in   engine busy
//   spi_data_out  in   16 engine read data, valid once spi_cs falls
// ----------------------------------------------------------------------------
module at93c46d_sequencer
    import at93c46d_pkg::*;
#(
    parameter int TWR_CYCLES   = 200000,
    parameter int CS_TIMEOUT   = 1024,
    parameter int XFER_TIMEOUT = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [5:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        spi_start,
    output logic [7:0]  spi_cmd,
    output logic [15:0] spi_data_in,
    input  logic        spi_cs,
    input  logic [15:0] spi_data_out
);

    localparam int CNT_MAX =
        (TWR_CYCLES > XFER_TIMEOUT)
            ? ((TWR_CYCLES > CS_TIMEOUT) ? TWR_CYCLES : CS_TIMEOUT)
            : ((XFER_TIMEOUT > CS_TIMEOUT) ? XFER_TIMEOUT : CS_TIMEOUT);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    state_t      state_q, state_d;
    step_t       step_q, step_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ewen_q, ewen_d;
    logic        ready_en;
    logic        accept;

    logic [1:0]  op_q;
    logic [5:0]  addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  op_sel;
    logic [5:0]  addr_sel;
    logic [15:0] wdata_sel;

    logic             tmr_load;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_limit;
    logic             tmr_done;

`ifdef AT93C46D_WRITE_VERIFY_EN
    logic [15:0] verify_word;
    assign verify_word = (op_q == OP_ERASE) ? 16'hFFFF : wdata_q;
`endif

    // ready_en is low during reset and for the first cycle after it.
    // req_ready therefore reads 0 in reset even though the FSM is already IDLE.
    assign req_ready = ready_en && (state_q == ST_IDLE) && !spi_cs;
    assign rsp_valid = (state_q == ST_RESP);
    assign spi_start = (state_q == ST_ISSUE);

    // The command that is issued in the accept cycle must use the live
    // request fields. Those fields are latched into op_q etc. in the same cycle.
    assign op_sel    = accept ? req_op    : op_q;
    assign addr_sel  = accept ? req_addr  : addr_q;
    assign wdata_sel = accept ? req_wdata : wdata_q;

    // Restart the timer on every state change, so each wait state measures
    // its own dwell time from zero.
    assign tmr_load = (state_d != state_q);
    assign tmr_en   = (state_q == ST_WAIT_CS_HI) || (state_q == ST_WAIT_CS_LO) ||
                      (state_q == ST_TWR_WAIT);

    always_comb begin
        tmr_limit = CNT_W'(CS_TIMEOUT);
        case (state_q)
            ST_WAIT_CS_LO: tmr_limit = CNT_W'(XFER_TIMEOUT);
            // done is asserted in the last of exactly TWR_CYCLES cycles.
            ST_TWR_WAIT:   tmr_limit = CNT_W'(TWR_CYCLES - 1);
            default:       tmr_limit = CNT_W'(CS_TIMEOUT);
        endcase
    end

    at93c46d_wait_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .en    (tmr_en),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        ewen_d  = ewen_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = 16'h0000;
                    ewen_d  = 1'b0;
                    if (req_op == OP_EWEN_EWDS) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_op == OP_READ) begin
                        step_d  = STEP_MAIN;
                        state_d = ST_ISSUE;
                    end else begin
                        step_d  = STEP_EWEN;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT_CS_HI;
            ST_WAIT_CS_HI, ST_WAIT_CS_LO: begin
                if ((state_q == ST_WAIT_CS_HI) && spi_cs) begin
                    state_d = ST_WAIT_CS_LO;
                end else if ((state_q == ST_WAIT_CS_LO) && !spi_cs) begin
                    case (step_q)
                        STEP_EWEN: begin
                            ewen_d  = 1'b1;
                            step_d  = STEP_MAIN;
                            state_d = ST_ISSUE;
                        end
                        STEP_MAIN: begin
                            if (op_q == OP_READ) begin
                                rdata_d = spi_data_out;
                                state_d = ST_RESP;
                            end else begin
                                state_d = ST_TWR_WAIT;
                            end
                        end
                        STEP_EWDS: begin
`ifdef AT93C46D_WRITE_VERIFY_EN
                            if (!err_q) begin
                                step_d  = STEP_VERIFY;
                                state_d = ST_ISSUE;
                            end else begin
                                state_d = ST_RESP;
                            end
`else
                            state_d = ST_RESP;
`endif
                        end
                        default: begin
`ifdef AT93C46D_WRITE_VERIFY_EN
                            rdata_d = spi_data_out;
                            if (spi_data_out != verify_word) begin
                                err_d = 1'b1;
                            end
`endif
                            state_d = ST_RESP;
                        end
                    endcase
                end else if (tmr_done) begin
                    // Abort. If EWEN already went through and the failing
                    // command was the program/erase itself, still try to
                    // write-protect the device with EWDS.
                    err_d = 1'b1;
                    if (ewen_q && (step_q == STEP_MAIN)) begin
                        step_d  = STEP_EWDS;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_TWR_WAIT: begin
                if (tmr_done) begin
                    step_d  = STEP_EWDS;
                    state_d = ST_ISSUE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_EWEN;
            err_q       <= 1'b0;
            rdata_q     <= 16'h0000;
            ewen_q      <= 1'b0;
            ready_en    <= 1'b0;
            spi_cmd     <= 8'h00;
            spi_data_in <= 16'h0000;
            rsp_rdata   <= 16'h0000;
            rsp_err     <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ewen_q   <= ewen_d;
            ready_en <= 1'b1;
            // The command and data are loaded as ISSUE is entered. They stay
            // unchanged until the next ISSUE, which covers the whole transfer.
            if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) begin
                spi_cmd     <= step_cmd(step_d, op_sel, addr_sel);
                spi_data_in <= ((step_d == STEP_MAIN) && (op_sel == OP_WRITE))
                               ? wdata_sel : 16'h0000;
            end
            if (state_d == ST_RESP) begin
                rsp_rdata <= rdata_d;
                rsp_err   <= err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

endmodule
